// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
// Imported by the arbiter top and its combinational datapath.
package addsub_arbiter_pkg;

    localparam int unsigned DefaultWidth = 32;

    localparam logic OpAdd = 1'b0;
    localparam logic OpSub = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit adder/subtractor with carry out of the MSB.
// Subtraction is a + ~b + 1, so carry = 1 means no borrow.
module addsub_unit
    import addsub_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff        = (sub == OpSub) ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result until consumed.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,

    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero
);

    state_e           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic [WIDTH-1:0] data_q;
    logic             carry_q;
    logic             zero_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;

    logic             grant;
    logic             accept;
    logic             owner_rsp_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    addsub_unit #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (a_q),
        .b     (b_q),
        .sub   (sub_q),
        .sum   (sum),
        .carry (carry)
    );

    // With both requesting, the one not served last wins; otherwise the lone requester.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst so no handshake completes on a reset edge.
    always_comb begin
        req0_ready      = !rst && (state_q == StIdle) && !grant && req0_valid;
        req1_ready      = !rst && (state_q == StIdle) &&  grant && req1_valid;
        accept          = req0_ready || req1_ready;
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= OpAdd;
            data_q       <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        owner_q      <= req1_ready;
                        last_grant_q <= req1_ready;
                        a_q          <= req1_ready ? req1_a   : req0_a;
                        b_q          <= req1_ready ? req1_b   : req0_b;
                        sub_q        <= req1_ready ? req1_sub : req0_sub;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    data_q       <= sum;
                    carry_q      <= carry;
                    zero_q       <= (sum == '0);
                    rsp0_valid_q <= !owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (owner_rsp_ready) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = data_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed-vector bench for addsub_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry, rsp_zero;

    int n_vec = 0;
    int n_bad = 0;

    addsub_arbiter #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full single-requester transaction starting in IDLE with no other request pending.
    task automatic do_op(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] exp_d, input logic exp_c,
                         input logic exp_z, input string tag);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end
        #1;
        chk({tag, "/ready"}, {req1_ready, req0_ready}, (n == 0) ? 32'd1 : 32'd2);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "/exec_rsp_valid"}, {rsp1_valid, rsp0_valid}, 32'd0);
        cyc();
        chk({tag, "/rsp_valid"}, {rsp1_valid, rsp0_valid}, (n == 0) ? 32'd1 : 32'd2);
        chk({tag, "/data"}, rsp_data, exp_d);
        chk({tag, "/carry"}, rsp_carry, exp_c);
        chk({tag, "/zero"}, rsp_zero, exp_z);
        if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk({tag, "/rsp_done"}, {rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
        chk("reset/ready", {req1_ready, req0_ready}, 32'd0);
        chk("reset/data", rsp_data, 32'd0);
        chk("reset/flags", {rsp_carry, rsp_zero}, 32'd0);
        rst = 1'b0;
        cyc();

        do_op(0, 32'd10, 32'd9, 1'b1, 32'd1, 1'b1, 1'b0, "t1_sub");
        do_op(1, 32'd4000, 32'd1000, 1'b1, 32'd3000, 1'b1, 1'b0, "t2_sub_a");
        do_op(1, 32'd65536, 32'd65540, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, "t2_sub_b");
        do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b1, "t3_add_wrap");

        // Both requesting continuously after reset: grants alternate starting with req0.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'd5; req1_b = 32'd3; req1_sub = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4/grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            cyc();
            chk("t4/exec_ready", {req1_ready, req0_ready}, 32'd0);
            chk("t4/exec_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
            cyc();
            chk("t4/rsp_owner", {rsp1_valid, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t4/data", rsp_data, (i % 2 == 0) ? 32'd3 : 32'd2);
            chk("t4/carry", rsp_carry, (i % 2 == 0) ? 32'd0 : 32'd1);
            cyc();
        end

        // Stalled response: req1 holds its result while req0 waits unserved.
        req0_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req1_a = 32'd1265536; req1_b = 32'd65540; req1_sub = 1'b1;
        #1;
        chk("t5/accept", {req1_ready, req0_ready}, 32'd2);
        cyc();
        req1_valid = 1'b0;
        req0_a = 32'd7; req0_b = 32'd7; req0_sub = 1'b1; req0_valid = 1'b1;
        #1;
        chk("t5/exec_ready", {req1_ready, req0_ready}, 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("t5/hold_valid", {rsp1_valid, rsp0_valid}, 32'd2);
            chk("t5/hold_data", rsp_data, 32'd1199996);
            chk("t5/hold_carry", rsp_carry, 32'd1);
            chk("t5/req0_blocked", req0_ready, 32'd0);
            rsp0_ready = (i == 2);
            cyc();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        chk("t5/released", {rsp1_valid, rsp0_valid}, 32'd0);
        chk("t5/waiter_wins", {req1_ready, req0_ready}, 32'd1);

        // Reset while req0's 7-7 op is in EXEC: it must vanish without a response.
        cyc();
        rst = 1'b1;
        req0_a = 32'd20; req0_b = 32'd5; req0_sub = 1'b0;
        req1_a = 32'd9; req1_b = 32'd1; req1_sub = 1'b0; req1_valid = 1'b1;
        cyc();
        chk("t6/rst_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
        chk("t6/rst_ready", {req1_ready, req0_ready}, 32'd0);
        chk("t6/rst_data", rsp_data, 32'd0);
        chk("t6/rst_flags", {rsp_carry, rsp_zero}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t6/first_grant", {req1_ready, req0_ready}, 32'd1);
        cyc();
        chk("t6/exec_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
        cyc();
        chk("t6/rsp_owner", {rsp1_valid, rsp0_valid}, 32'd1);
        chk("t6/data", rsp_data, 32'd25);
        chk("t6/flags", {rsp_carry, rsp_zero}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        chk("t6/done", {rsp1_valid, rsp0_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
